// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI encodings and the data/strobe widths used by the DMA.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 256
`endif
package axi_pkg;
  localparam int DMA_DW = `DMA_DATA_WIDTH;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef logic [DMA_DW/8-1:0] axi_strb_t;
endpackage

// File: rtl/dma_pkg.sv
// dma_pkg: DMA request/response/error types and the read-tracker entry.
package dma_pkg;
  import axi_pkg::*;
  typedef enum logic [2:0] {
    DMA_NO_ERR      = 3'd0,
    DMA_WR_RESP_ERR = 3'd1,
    DMA_DESC_ERR    = 3'd2,
    DMA_RD_RESP_ERR = 3'd3,
    DMA_RD_LEN_ERR  = 3'd4
  } dma_err_src_e;
  typedef struct packed {
    logic         valid;
    dma_err_src_e src;
    logic [31:0]  addr;
  } s_dma_error_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [2:0]  size;
    axi_strb_t   strb;
    logic        valid;
  } s_dma_axi_req_t;
  typedef struct packed {
    logic ready;
  } s_dma_axi_resp_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  alen;
    axi_strb_t   strb;
  } rd_trk_ent_t;
endpackage

// File: rtl/dma_rd_tracker_fifo.sv
// dma_rd_tracker_fifo: power-of-2 deep FIFO holding accepted-but-unfinished read bursts.
module dma_rd_tracker_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q[AW];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_q <= do_pop ? rptr_q + AW'(1) : rptr_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/dma_rd_channel.sv
// dma_rd_channel: AXI read channel for the DMA read streamer with outstanding-burst tracking.
// Optional DMA_RD_RLAST_CHECK_EN checks rlast against the tracked burst length.
module dma_rd_channel
  import axi_pkg::*;
  import dma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  s_dma_axi_req_t                        dma_axi_req_i,
  output s_dma_axi_resp_t                       dma_axi_resp_o,
  output logic [31:0]                           araddr_o,
  output logic [7:0]                            arlen_o,
  output logic [2:0]                            arsize_o,
  output logic [1:0]                            arburst_o,
  output logic                                  arvalid_o,
  input  logic                                  arready_i,
  input  logic [`DMA_DATA_WIDTH-1:0]            rdata_i,
  input  logic [1:0]                            rresp_i,
  input  logic                                  rlast_i,
  input  logic                                  rvalid_i,
  output logic                                  rready_o,
  output logic [`DMA_DATA_WIDTH-1:0]            rd_data_o,
  output axi_strb_t                             rd_strb_o,
  output logic                                  rd_valid_o,
  input  logic                                  rd_ready_i,
  output s_dma_error_t                          rd_err_o,
  input  logic                                  err_clear_i,
  output logic                                  idle_o,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  rd_trk_ent_t ent, head;
  logic full, empty, ar_hs, r_hs, pop, resp_bad, len_bad;
  logic [CW-1:0] count;
  logic [7:0] beat_q, beat_d;
  s_dma_error_t err_q, err_d;
  assign ent = '{addr: dma_axi_req_i.addr, alen: dma_axi_req_i.alen, strb: dma_axi_req_i.strb};
  dma_rd_tracker_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .W($bits(rd_trk_ent_t))
  ) u_trk (
    .clk(clk),
    .rst(rst),
    .push_i(ar_hs),
    .din_i(ent),
    .pop_i(pop),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  assign arvalid_o = dma_axi_req_i.valid & ~full;
  assign araddr_o = dma_axi_req_i.addr;
  assign arlen_o = dma_axi_req_i.alen;
  assign arsize_o = dma_axi_req_i.size;
  assign arburst_o = AXI_BURST_INCR;
  assign dma_axi_resp_o = '{ready: arready_i & ~full};
  assign ar_hs = arvalid_o & arready_i;
  // An empty tracker means the slave sent an unrequested beat; leave it unconsumed.
  assign rready_o = rd_ready_i & ~empty;
  assign rd_valid_o = rvalid_i & ~empty;
  assign rd_data_o = rdata_i;
  assign rd_strb_o = head.strb;
  assign r_hs = rvalid_i & rready_o;
  assign resp_bad = r_hs & (rresp_i != AXI_RESP_OKAY);
`ifdef DMA_RD_RLAST_CHECK_EN
  logic last_beat;
  assign last_beat = beat_q == head.alen;
  assign pop = r_hs & (rlast_i | last_beat);
  assign len_bad = r_hs & (rlast_i ^ last_beat);
`else
  logic unused_alen;
  assign unused_alen = ^head.alen;
  assign pop = r_hs & rlast_i;
  assign len_bad = 1'b0;
`endif
  // A new error wins over a simultaneous clear; otherwise the first error sticks.
  always_comb begin
    beat_d = r_hs ? (pop ? 8'd0 : beat_q + 8'd1) : beat_q;
    err_d = ((resp_bad | len_bad) & (~err_q.valid | err_clear_i))
          ? s_dma_error_t'{valid: 1'b1, src: resp_bad ? DMA_RD_RESP_ERR : DMA_RD_LEN_ERR, addr: head.addr}
          : err_clear_i ? s_dma_error_t'('0) : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      err_q <= '0;
    end else begin
      beat_q <= beat_d;
      err_q <= err_d;
    end
  end
  assign rd_err_o = err_q;
  assign idle_o = empty & ~dma_axi_req_i.valid;
  assign outstanding_o = count;
endmodule

// File: tb/tb_dma_rd_channel.sv
// tb_dma_rd_channel: vector table, corner sequences and random traffic against a queue model.
module tb_dma_rd_channel;
  import axi_pkg::*;
  import dma_pkg::*;
  localparam int MAXO = 4;
  localparam int DW = DMA_DW;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  s_dma_axi_req_t req;
  s_dma_axi_resp_t resp;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp;
  logic arvalid, arready, rlast, rvalid, rready, rd_valid, rd_ready, err_clear, idle;
  logic [DW-1:0] rdata, rd_data;
  axi_strb_t rd_strb;
  s_dma_error_t rd_err;
  logic [$clog2(MAXO):0] outst;
  dma_rd_channel #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .dma_axi_req_i(req), .dma_axi_resp_o(resp),
    .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arvalid_o(arvalid), .arready_i(arready), .rdata_i(rdata), .rresp_i(rresp),
    .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready), .rd_data_o(rd_data),
    .rd_strb_o(rd_strb), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_err_o(rd_err), .err_clear_i(err_clear), .idle_o(idle), .outstanding_o(outst)
  );
  int nvec = 0, nerr = 0;
  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    axi_strb_t   strb;
  } ent_t;
  ent_t q[$];
  int beat;
  logic ev;
  dma_err_src_e esrc;
  logic [31:0] eaddr;
  task automatic model_check();
    bit full = q.size() == MAXO;
    bit empty = q.size() == 0;
    cmp("arvalid", arvalid, req.valid && !full);
    cmp("ready", resp.ready, arready && !full);
    cmp("araddr", araddr, req.addr);
    cmp("arlen", arlen, req.alen);
    cmp("arsize", arsize, req.size);
    cmp("arburst", arburst, 2'b01);
    cmp("rready", rready, rd_ready && !empty);
    cmp("rd_valid", rd_valid, rvalid && !empty);
    cmp("rd_data", rd_data, rdata);
    if (!empty) cmp("rd_strb", rd_strb, q[0].strb);
    cmp("idle", idle, empty && !req.valid);
    cmp("outstanding", outst, q.size());
    cmp("rd_err", rd_err, {ev, esrc, eaddr});
  endtask
  task automatic model_update();
    bit full, empty, ar, r, pop, lbad, rbad;
    logic [31:0] haddr;
    if (rst) begin
      q.delete();
      beat = 0;
      ev = 1'b0;
      esrc = DMA_NO_ERR;
      eaddr = '0;
      return;
    end
    full = q.size() == MAXO;
    empty = q.size() == 0;
    ar = req.valid && arready && !full;
    r = rvalid && rd_ready && !empty;
    pop = 0;
    lbad = 0;
    rbad = 0;
    haddr = empty ? 32'h0 : q[0].addr;
    if (r) begin
`ifdef DMA_RD_RLAST_CHECK_EN
      bit at_end;
      at_end = beat == int'(q[0].alen);
      pop = rlast || at_end;
      lbad = rlast != at_end;
`else
      pop = rlast;
`endif
      rbad = rresp != 2'b00;
      beat = pop ? 0 : beat + 1;
    end
    if ((rbad || lbad) && (!ev || err_clear)) begin
      ev = 1'b1;
      esrc = rbad ? DMA_RD_RESP_ERR : DMA_RD_LEN_ERR;
      eaddr = haddr;
    end else if (err_clear) begin
      ev = 1'b0;
      esrc = DMA_NO_ERR;
      eaddr = '0;
    end
    if (pop) void'(q.pop_front());
    if (ar) q.push_back('{req.addr, req.alen, req.strb});
  endtask
  task automatic drive(input bit r, v, input logic [31:0] a, input logic [7:0] l, input axi_strb_t s,
                       input bit ard, rv, rl, input logic [1:0] rr, input bit rdy, clr);
    rst = r;
    req.valid = v;
    req.addr = a;
    req.alen = l;
    req.size = 3'd5;
    req.strb = s;
    arready = ard;
    rvalid = rv;
    rlast = rl;
    rresp = rr;
    rd_ready = rdy;
    err_clear = clr;
  endtask
  task automatic settle();
    #1;
    model_check();
  endtask
  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic idle_cyc();
    drive(0, 0, 0, 0, '0, 0, 0, 0, 2'b00, 0, 0);
    settle();
  endtask
  task automatic do_reset();
    drive(1, 0, 0, 0, '0, 0, 0, 0, 2'b00, 0, 0);
    adv();
  endtask
  typedef struct {
    bit rst, v;
    logic [31:0] a;
    logic [7:0] l;
    bit ard, rv, rl;
    logic [1:0] rr;
    bit rdy, clr;
    bit e_ready, e_rready, e_rdv;
    int e_out;
    bit e_ev;
    dma_err_src_e e_src;
    logic [31:0] e_addr;
    bit e_idle;
  } vec_t;
  vec_t tbl[19];
  logic [DW-1:0] pat;
  initial begin
    tbl[0]  = '{0,1,32'h1000,3,1,1,0,2'b00,1,0, 1,0,0,0, 0,DMA_NO_ERR,32'h0,0};
    tbl[1]  = '{0,0,32'h0,0,0,1,0,2'b00,1,0,    0,1,1,1, 0,DMA_NO_ERR,32'h0,0};
    tbl[2]  = '{0,0,32'h0,0,0,1,0,2'b00,1,0,    0,1,1,1, 0,DMA_NO_ERR,32'h0,0};
    tbl[3]  = '{0,0,32'h0,0,0,1,0,2'b00,1,0,    0,1,1,1, 0,DMA_NO_ERR,32'h0,0};
    tbl[4]  = '{0,0,32'h0,0,0,1,1,2'b00,1,0,    0,1,1,1, 0,DMA_NO_ERR,32'h0,0};
    tbl[5]  = '{0,0,32'h0,0,0,0,0,2'b00,0,0,    0,0,0,0, 0,DMA_NO_ERR,32'h0,1};
    tbl[6]  = '{0,1,32'h2000,3,1,0,0,2'b00,0,0, 1,0,0,0, 0,DMA_NO_ERR,32'h0,0};
    tbl[7]  = '{0,0,32'h0,0,0,1,0,2'b00,1,0,    0,1,1,1, 0,DMA_NO_ERR,32'h0,0};
    tbl[8]  = '{0,0,32'h0,0,0,1,0,2'b10,1,0,    0,1,1,1, 0,DMA_NO_ERR,32'h0,0};
    tbl[9]  = '{0,0,32'h0,0,0,1,0,2'b10,1,0,    0,1,1,1, 1,DMA_RD_RESP_ERR,32'h2000,0};
    tbl[10] = '{0,0,32'h0,0,0,1,1,2'b00,1,0,    0,1,1,1, 1,DMA_RD_RESP_ERR,32'h2000,0};
    tbl[11] = '{0,1,32'h2400,0,1,0,0,2'b00,0,0, 1,0,0,0, 1,DMA_RD_RESP_ERR,32'h2000,0};
    tbl[12] = '{0,0,32'h0,0,0,1,1,2'b10,1,0,    0,1,1,1, 1,DMA_RD_RESP_ERR,32'h2000,0};
    tbl[13] = '{0,0,32'h0,0,0,0,0,2'b00,0,1,    0,0,0,0, 1,DMA_RD_RESP_ERR,32'h2000,1};
    tbl[14] = '{0,0,32'h0,0,0,0,0,2'b00,0,0,    0,0,0,0, 0,DMA_NO_ERR,32'h0,1};
    tbl[15] = '{0,1,32'h3000,1,1,0,0,2'b00,0,0, 1,0,0,0, 0,DMA_NO_ERR,32'h0,0};
    tbl[16] = '{0,1,32'h3100,1,1,0,0,2'b00,0,0, 1,0,0,1, 0,DMA_NO_ERR,32'h0,0};
    tbl[17] = '{1,0,32'h0,0,0,0,0,2'b00,0,0,    0,0,0,2, 0,DMA_NO_ERR,32'h0,0};
    tbl[18] = '{0,0,32'h0,0,0,0,0,2'b00,0,0,    0,0,0,0, 0,DMA_NO_ERR,32'h0,1};
    rdata = '0;
    do_reset();
    do_reset();
    drive(0, 0, 0, 0, '0, 0, 1, 0, 2'b00, 1, 0);
    settle();
    cmp("rst_arvalid", arvalid, 1'b0);
    cmp("rst_ready", resp.ready, 1'b0);
    cmp("rst_rready", rready, 1'b0);
    cmp("rst_rd_valid", rd_valid, 1'b0);
    cmp("rst_idle", idle, 1'b1);
    cmp("rst_outstanding", outst, 0);
    cmp("rst_err", rd_err, 0);
    adv();
    for (int i = 0; i < 19; i++) begin
      rdata = DW'(i * 32'h1111);
      drive(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].l, '1, tbl[i].ard, tbl[i].rv, tbl[i].rl,
            tbl[i].rr, tbl[i].rdy, tbl[i].clr);
      settle();
      cmp($sformatf("tbl%0d_ready", i), resp.ready, tbl[i].e_ready);
      cmp($sformatf("tbl%0d_rready", i), rready, tbl[i].e_rready);
      cmp($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].e_rdv);
      cmp($sformatf("tbl%0d_outstanding", i), outst, tbl[i].e_out);
      cmp($sformatf("tbl%0d_err", i), rd_err, {tbl[i].e_ev, tbl[i].e_src, tbl[i].e_addr});
      cmp($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
      adv();
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h6000 + i * 32'h100, 0, '1, 1, 0, 0, 2'b00, 0, 0);
      settle();
      cmp("bp_accept", resp.ready, 1'b1);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h6400, 0, '1, 1, 0, 0, 2'b00, 0, 0);
      settle();
      cmp("bp_full_ready", resp.ready, 1'b0);
      cmp("bp_full_arvalid", arvalid, 1'b0);
      cmp("bp_full_outst", outst, 4);
      adv();
    end
    drive(0, 1, 32'h6400, 0, '1, 1, 1, 1, 2'b00, 1, 0);
    settle();
    cmp("bp_pop_ready", resp.ready, 1'b0);
    adv();
    drive(0, 1, 32'h6400, 0, '1, 1, 0, 0, 2'b00, 0, 0);
    settle();
    cmp("bp_after_pop_ready", resp.ready, 1'b1);
    cmp("bp_after_pop_outst", outst, 3);
    adv();
    idle_cyc();
    cmp("bp_refill_outst", outst, 4);
    adv();
    do_reset();
    drive(0, 1, 32'h4000, 0, 32'h0000_FF00, 1, 0, 0, 2'b00, 0, 0);
    settle();
    adv();
    for (int k = 0; k < DW / 32; k++) pat[k*32 +: 32] = 32'hA5A5_0000 + k;
    rdata = pat;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, '0, 0, 1, 1, 2'b00, 0, 0);
      settle();
      cmp("hold_rready", rready, 1'b0);
      cmp("hold_rd_valid", rd_valid, 1'b1);
      cmp("hold_rd_data", rd_data, pat);
      cmp("hold_rd_strb", rd_strb, 32'h0000_FF00);
      cmp("hold_outst", outst, 1);
      adv();
    end
    drive(0, 0, 0, 0, '0, 0, 1, 1, 2'b00, 1, 0);
    settle();
    cmp("hold_release_rready", rready, 1'b1);
    adv();
    idle_cyc();
    cmp("hold_done_outst", outst, 0);
    adv();
    do_reset();
    drive(0, 1, 32'h5000, 7, '1, 1, 0, 0, 2'b00, 0, 0);
    settle();
    adv();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, '0, 0, 1, i == 4, 2'b00, 1, 0);
      settle();
      adv();
    end
    idle_cyc();
    cmp("len_early_outst", outst, 0);
`ifdef DMA_RD_RLAST_CHECK_EN
    cmp("len_early_err", rd_err, {1'b1, DMA_RD_LEN_ERR, 32'h5000});
`else
    cmp("len_early_err", rd_err, 0);
`endif
    adv();
    drive(0, 1, 32'h5100, 1, '1, 1, 0, 0, 2'b00, 0, 1);
    settle();
    adv();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, '0, 0, 1, 0, 2'b00, 1, 0);
      settle();
      adv();
    end
    idle_cyc();
`ifdef DMA_RD_RLAST_CHECK_EN
    cmp("len_missing_outst", outst, 0);
    cmp("len_missing_err", rd_err, {1'b1, DMA_RD_LEN_ERR, 32'h5100});
`else
    cmp("len_missing_outst", outst, 1);
    cmp("len_missing_err", rd_err, 0);
`endif
    adv();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < DW / 32; k++) rdata[k*32 +: 32] = $urandom;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom,
            8'($urandom_range(0, 3)), axi_strb_t'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      req.size = 3'($urandom);
      settle();
      adv();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
